// File: rtl/regbank_spill_ctrl_pkg.sv
// Shared definitions for the banked register file spill/fill sequencer:
// save order, frame size and FSM state encoding.
package regbank_spill_ctrl_pkg;

  localparam int unsigned NR_SAVED = 16;
  localparam logic [4:0]  SP_ADDR  = 5'd2;

  typedef enum logic [2:0] {
    StIdle,
    StSpill,
    StSpUpd,
    StFillReq,
    StFillWait,
    StSwitch
  } state_e;

  // Caller-saved registers in stack-slot order: ra, t0-t2, a0-a7, t3-t6.
  localparam logic [4:0] SAVE_ORDER [NR_SAVED] = '{
    5'd1,  5'd5,  5'd6,  5'd7,  5'd10, 5'd11, 5'd12, 5'd13,
    5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31
  };

  function automatic logic [4:0] saved_reg(input logic [3:0] idx);
    return SAVE_ORDER[idx];
  endfunction

endpackage

// File: rtl/regbank_spill_ctrl_if.sv
// Signals between the spill sequencer, the commit/exception logic, the two
// register file banks and the dcache store/load port.
interface regbank_spill_ctrl_if #(
  parameter int unsigned XLEN = 64
);

  logic            ex_valid_i;
  logic            eret_i;
  logic [XLEN-1:0] sp_i;
  logic            bank_sel_o;
  logic            busy_o;
  logic            err_o;
  logic [4:0]      rf_raddr_o;
  logic [XLEN-1:0] rf_rdata_i;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            rf_we_o;
  logic            rf_wbank_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // Sequencer side.
  modport master (
    input  ex_valid_i, eret_i, sp_i, rf_rdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output bank_sel_o, busy_o, err_o, rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           rf_wbank_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Pipeline / regfile / dcache side.
  modport slave (
    output ex_valid_i, eret_i, sp_i, rf_rdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  bank_sel_o, busy_o, err_o, rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           rf_wbank_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/regbank_spill_ctrl.sv
// Bank-switch sequencer: on exception spills the old bank's caller-saved registers
// to the stack and sets the new bank's sp; on return fills them back and switches.
module regbank_spill_ctrl
  import regbank_spill_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH_MAX = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regbank_spill_ctrl_if.master ctrl_io
);

  localparam int unsigned SlotBytes  = XLEN / 8;
  localparam int unsigned FrameBytes = NR_SAVED * SlotBytes;
  localparam int unsigned DepthW     = $clog2(DEPTH_MAX + 1);
  localparam logic [3:0]  LastIdx    = 4'(NR_SAVED - 1);

  function automatic logic [XLEN-1:0] slot_addr(input logic [XLEN-1:0] base,
                                                input logic [3:0]      idx);
    return base + XLEN'(idx) * XLEN'(SlotBytes);
  endfunction

  state_e             state_q;
  logic [3:0]         idx_q;
  logic [DepthW-1:0]  depth_q;
  logic               pending_q;
  logic               bank_q;
  logic               err_q;
  logic [XLEN-1:0]    base_q;
  logic [4:0]         raddr_q;
  logic [4:0]         waddr_q;
  logic [XLEN-1:0]    wdata_q;
  logic               rf_we_q;
  logic               wbank_q;
  logic               req_q;
  logic               mem_we_q;
  logic [XLEN-1:0]    addr_q;

  logic               busy;
  logic               ex_trig;
  logic [3:0]         idx_nxt;
  logic [XLEN-1:0]    spill_base;

  assign busy       = (state_q != StIdle);
  assign ex_trig    = ctrl_io.ex_valid_i | pending_q;
  assign idx_nxt    = idx_q + 4'd1;
  assign spill_base = ctrl_io.sp_i - XLEN'(FrameBytes);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      depth_q   <= '0;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      err_q     <= 1'b0;
      base_q    <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rf_we_q   <= 1'b0;
      wbank_q   <= 1'b0;
      req_q     <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
    end else begin
      rf_we_q <= 1'b0;
      // Exceptions arriving mid-sequence queue one deep; returns cannot be queued.
      if (busy && ctrl_io.ex_valid_i) begin
        if (pending_q) err_q <= 1'b1;
        else           pending_q <= 1'b1;
      end
      if (busy && ctrl_io.eret_i) err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (ex_trig) begin
            pending_q <= ctrl_io.ex_valid_i & pending_q;
            if (ctrl_io.eret_i) err_q <= 1'b1;
            if (depth_q < DepthW'(DEPTH_MAX)) begin
              base_q   <= spill_base;
              bank_q   <= ~bank_q;
              idx_q    <= '0;
              raddr_q  <= saved_reg(4'd0);
              addr_q   <= spill_base;
              req_q    <= 1'b1;
              mem_we_q <= 1'b1;
              state_q  <= StSpill;
            end else begin
              err_q <= 1'b1;
            end
          end else if (ctrl_io.eret_i && depth_q != '0) begin
            base_q   <= ctrl_io.sp_i;
            idx_q    <= '0;
            addr_q   <= ctrl_io.sp_i;
            req_q    <= 1'b1;
            mem_we_q <= 1'b0;
            state_q  <= StFillReq;
          end
        end
        StSpill: begin
          if (ctrl_io.mem_gnt_i) begin
            if (idx_q == LastIdx) begin
              req_q    <= 1'b0;
              mem_we_q <= 1'b0;
              rf_we_q  <= 1'b1;
              wbank_q  <= bank_q;
              waddr_q  <= SP_ADDR;
              wdata_q  <= base_q;
              state_q  <= StSpUpd;
            end else begin
              idx_q   <= idx_nxt;
              raddr_q <= saved_reg(idx_nxt);
              addr_q  <= slot_addr(base_q, idx_nxt);
            end
          end
        end
        StSpUpd: begin
          depth_q <= depth_q + DepthW'(1);
          state_q <= StIdle;
        end
        StFillReq: begin
          if (ctrl_io.mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= StFillWait;
          end
        end
        StFillWait: begin
          if (ctrl_io.mem_rvalid_i) begin
            rf_we_q <= 1'b1;
            wbank_q <= ~bank_q;
            waddr_q <= saved_reg(idx_q);
            wdata_q <= ctrl_io.mem_rdata_i;
            if (idx_q == LastIdx) begin
              state_q <= StSwitch;
            end else begin
              idx_q   <= idx_nxt;
              addr_q  <= slot_addr(base_q, idx_nxt);
              req_q   <= 1'b1;
              state_q <= StFillReq;
            end
          end
        end
        StSwitch: begin
          bank_q  <= ~bank_q;
          depth_q <= depth_q - DepthW'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl_io.bank_sel_o  = bank_q;
  assign ctrl_io.busy_o      = busy;
  assign ctrl_io.err_o       = err_q;
  assign ctrl_io.rf_raddr_o  = raddr_q;
  assign ctrl_io.rf_waddr_o  = waddr_q;
  assign ctrl_io.rf_wdata_o  = wdata_q;
  assign ctrl_io.rf_we_o     = rf_we_q;
  assign ctrl_io.rf_wbank_o  = wbank_q;
  assign ctrl_io.mem_req_o   = req_q;
  assign ctrl_io.mem_we_o    = mem_we_q;
  assign ctrl_io.mem_addr_o  = addr_q;
  // Regfile read is combinational, so store data must bypass the output registers.
  assign ctrl_io.mem_wdata_o = (req_q && mem_we_q) ? ctrl_io.rf_rdata_i : '0;

endmodule

// File: tb/tb_regbank_spill_ctrl.sv
// Bench for regbank_spill_ctrl: two-bank regfile and dcache models around the DUT,
// with expected stores, loads and regfile writes queued ahead and compared as they occur.
module tb_regbank_spill_ctrl;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned DEPTH_MAX = 7;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } st_t;

  typedef struct packed {
    logic        bank;
    logic [4:0]  addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst_n;

  regbank_spill_ctrl_if #(.XLEN(XLEN)) bus ();

  regbank_spill_ctrl #(
    .XLEN      (XLEN),
    .DEPTH_MAX (DEPTH_MAX)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ctrl_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [4:0] order [16] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13,
                             5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31};

  function automatic logic [63:0] pat(input int b, input int r);
    return 64'hC0DE_0000_0000_0000 | (64'(b) << 16) | 64'(r);
  endfunction

  // Environment: two register banks and a byte-addressed memory.
  logic [63:0] rf [2][32];
  logic [63:0] mem [logic [63:0]];

  assign bus.sp_i       = rf[bus.bank_sel_o][2];
  assign bus.rf_rdata_i = rf[~bus.bank_sel_o][bus.rf_raddr_o];

  always @(posedge clk) begin
    if (bus.rf_we_o) rf[bus.rf_wbank_o][bus.rf_waddr_o] = bus.rf_wdata_o;
  end

  // Expected-side model.
  st_t         sq [$];
  wr_t         wq [$];
  logic [63:0] lq [$];
  logic        exp_bank;
  logic [63:0] exp_sp [2];
  logic [63:0] exp_mem [logic [63:0]];

  // Dcache responder: grant requests (optionally stalling one slot), data 2 cycles after gnt.
  logic [63:0] stall_addr = '1;
  int          stall_n    = 0;
  int          stall_cnt  = 0;
  int          ld_wait    = 0;
  logic [63:0] ld_addr    = '0;

  always @(posedge clk) begin
    #1;
    bus.mem_rvalid_i = 1'b0;
    if (!rst_n) begin
      ld_wait          = 0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rdata_i  = '0;
    end else begin
      if (ld_wait > 0) begin
        ld_wait--;
        if (ld_wait == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem[ld_addr];
        end
      end
      if (bus.mem_req_o && bus.mem_addr_o == stall_addr && stall_cnt < stall_n) begin
        bus.mem_gnt_i = 1'b0;
        stall_cnt++;
      end else begin
        bus.mem_gnt_i = bus.mem_req_o;
      end
      if (bus.mem_req_o && bus.mem_gnt_i && !bus.mem_we_o) begin
        ld_wait = 2;
        ld_addr = bus.mem_addr_o;
      end
    end
  end

  // Monitor: compares each accepted store/load and each regfile write against the queues.
  logic        was_stall = 1'b0;
  logic [63:0] hold_a, hold_d;
  st_t         se;
  wr_t         we_e;
  logic [63:0] le;

  always @(negedge clk) begin
    if (!rst_n) begin
      was_stall = 1'b0;
    end else begin
      if (was_stall && bus.mem_req_o) begin
        check_eq("hold_addr", bus.mem_addr_o, hold_a);
        check_eq("hold_wdata", bus.mem_wdata_o, hold_d);
      end
      was_stall = bus.mem_req_o && !bus.mem_gnt_i;
      hold_a    = bus.mem_addr_o;
      hold_d    = bus.mem_wdata_o;
      if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_we_o) begin
        mem[bus.mem_addr_o] = bus.mem_wdata_o;
        check_eq("store_expected", 64'(sq.size() != 0), 64'd1);
        if (sq.size() != 0) begin
          se = sq.pop_front();
          check_eq("store_addr", bus.mem_addr_o, se.addr);
          check_eq("store_data", bus.mem_wdata_o, se.data);
          if (se.cyc >= 0) check_eq("store_cycle", 64'(cyc), 64'(se.cyc));
        end
      end
      if (bus.mem_req_o && bus.mem_gnt_i && !bus.mem_we_o) begin
        check_eq("load_expected", 64'(lq.size() != 0), 64'd1);
        if (lq.size() != 0) begin
          le = lq.pop_front();
          check_eq("load_addr", bus.mem_addr_o, le);
        end
      end
      if (bus.rf_we_o) begin
        check_eq("rfw_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          we_e = wq.pop_front();
          check_eq("rfw_bank", 64'(bus.rf_wbank_o), 64'(we_e.bank));
          check_eq("rfw_addr", 64'(bus.rf_waddr_o), 64'(we_e.addr));
          check_eq("rfw_data", bus.rf_wdata_o, we_e.data);
          if (we_e.cyc >= 0) check_eq("rfw_cycle", 64'(cyc), 64'(we_e.cyc));
        end
      end
    end
  end

  task automatic push_spill(input int first);
    logic        b;
    logic [63:0] base, a, d;
    b    = exp_bank;
    base = exp_sp[b] - 64'd128;
    for (int i = 0; i < 16; i++) begin
      a = base + 64'(i * 8);
      d = pat(int'(b), int'(order[i]));
      sq.push_back(st_t'{addr: a, data: d, cyc: (first < 0) ? -1 : first + i});
      exp_mem[a] = d;
    end
    wq.push_back(wr_t'{bank: ~b, addr: 5'd2, data: base, cyc: (first < 0) ? -1 : first + 16});
    exp_sp[~b] = base;
    exp_bank   = ~b;
  endtask

  task automatic push_fill();
    logic        b;
    logic [63:0] base, a;
    b    = exp_bank;
    base = exp_sp[b];
    for (int i = 0; i < 16; i++) begin
      a = base + 64'(i * 8);
      lq.push_back(a);
      wq.push_back(wr_t'{bank: ~b, addr: order[i], data: exp_mem[a], cyc: -1});
    end
    exp_bank = ~b;
  endtask

  task automatic pulse_ex();
    bus.ex_valid_i = 1'b1;
    @(negedge clk);
    bus.ex_valid_i = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret_i = 1'b1;
    @(negedge clk);
    bus.eret_i = 1'b0;
  endtask

  // Waits until the DUT is idle and every expected event has been seen.
  task automatic wait_done(input string tag, input int budget, output int done_cyc);
    int  n;
    logic pending;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      pending = bus.busy_o || sq.size() != 0 || wq.size() != 0 || lq.size() != 0;
    end while (pending && n < budget);
    check_eq({tag, "_done"}, 64'(pending), 64'd0);
    done_cyc = cyc;
  endtask

  int          first, done_c;
  logic        saved_bank, found;
  logic [63:0] saved_sp0, saved_sp1, abort_base;

  initial begin
    rst_n          = 1'b0;
    bus.ex_valid_i = 1'b0;
    bus.eret_i     = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++) rf[b][r] = pat(b, r);
    rf[0][2]  = 64'h8000_1000;
    rf[1][2]  = 64'h0;
    exp_bank  = 1'b0;
    exp_sp[0] = 64'h8000_1000;
    exp_sp[1] = 64'h0;

    repeat (3) @(negedge clk);
    check_eq("rst_bank_sel", 64'(bus.bank_sel_o), 64'd0);
    check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
    check_eq("rst_err", 64'(bus.err_o), 64'd0);
    check_eq("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    check_eq("rst_rf_we", 64'(bus.rf_we_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Spill with gnt always granted: exact cycle timing.
    first = cyc + 1;
    push_spill(first);
    pulse_ex();
    wait_done("spill1", 60, done_c);
    check_eq("spill1_idle_cycle", 64'(done_c), 64'(first + 17));
    check_eq("spill1_bank_sel", 64'(bus.bank_sel_o), 64'd1);
    check_eq("spill1_err", 64'(bus.err_o), 64'd0);

    // Fill back into bank 0.
    push_fill();
    pulse_eret();
    wait_done("fill1", 200, done_c);
    check_eq("fill1_bank_sel", 64'(bus.bank_sel_o), 64'd0);
    check_eq("fill1_err", 64'(bus.err_o), 64'd0);

    // Return at depth 0 is ignored.
    pulse_eret();
    repeat (5) @(negedge clk);
    #1;
    check_eq("eret0_busy", 64'(bus.busy_o), 64'd0);
    check_eq("eret0_bank_sel", 64'(bus.bank_sel_o), 64'd0);
    check_eq("eret0_err", 64'(bus.err_o), 64'd0);

    // Spill with a 3-cycle stall at idx 4, plus a pending exception and a dropped one.
    stall_addr = exp_sp[exp_bank] - 64'd128 + 64'd32;
    stall_n    = 3;
    push_spill(-1);
    pulse_ex();
    repeat (2) @(negedge clk);
    push_spill(-1);
    pulse_ex();
    check_eq("pend_err_before", 64'(bus.err_o), 64'd0);
    pulse_ex();
    wait_done("pend", 120, done_c);
    check_eq("pend_err", 64'(bus.err_o), 64'd1);
    check_eq("pend_bank_sel", 64'(bus.bank_sel_o), 64'd0);
    check_eq("pend_stalls", 64'(stall_cnt), 64'd3);

    // Reset in the middle of a spill.
    saved_bank = exp_bank;
    saved_sp0  = exp_sp[0];
    saved_sp1  = exp_sp[1];
    abort_base = exp_sp[exp_bank] - 64'd128;
    push_spill(-1);
    pulse_ex();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      #1;
      found = bus.mem_req_o && bus.mem_addr_o == abort_base + 64'd56;
    end
    check_eq("abort_reach_idx7", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_mem_req", 64'(bus.mem_req_o), 64'd0);
    check_eq("abort_bank_sel", 64'(bus.bank_sel_o), 64'd0);
    check_eq("abort_busy", 64'(bus.busy_o), 64'd0);
    sq.delete();
    wq.delete();
    lq.delete();
    exp_bank  = saved_bank;
    exp_sp[0] = saved_sp0;
    exp_sp[1] = saved_sp1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_err_cleared", 64'(bus.err_o), 64'd0);

    // Fresh spill from idx 0, then nest up to DEPTH_MAX.
    first = cyc + 1;
    push_spill(first);
    pulse_ex();
    wait_done("fresh", 60, done_c);
    check_eq("fresh_idle_cycle", 64'(done_c), 64'(first + 17));
    for (int k = 1; k < DEPTH_MAX; k++) begin
      push_spill(-1);
      pulse_ex();
      wait_done("nest", 60, done_c);
    end
    check_eq("nest_bank_sel", 64'(bus.bank_sel_o), 64'(exp_bank));
    check_eq("nest_err", 64'(bus.err_o), 64'd0);

    // One more exception at full depth: no switch, no stores, error.
    pulse_ex();
    repeat (4) @(negedge clk);
    #1;
    check_eq("full_busy", 64'(bus.busy_o), 64'd0);
    check_eq("full_bank_sel", 64'(bus.bank_sel_o), 64'(exp_bank));
    check_eq("full_err", 64'(bus.err_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regbank_spill_ctrl.md
Name: regbank_spill_ctrl

Overview:
Sequencer for the banked integer register file. On an exception it switches the active bank and spills the 16 caller-saved registers of the old bank to the stack through a dcache-style store port. It then sets the new bank's sp. On exception return it fills those registers back from the stack into the inactive bank and switches back. It sits between commit/exception logic, the two regfile banks and one dcache request port.

Parameters:
XLEN, 64, data/address width (32 or 64)
NR_SAVED, 16, number of spilled registers (fixed order table below)
DEPTH_MAX, 7, maximum nesting depth tracked

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
ex_valid_i  in  1  exception taken, spill trigger (1-cycle pulse)
eret_i  in  1  exception return, fill trigger (1-cycle pulse)
sp_i  in  XLEN  current x2 of active bank
bank_sel_o  out  1  active bank index for the pipeline
busy_o  out  1  sequence in progress; pipeline stalls commit
err_o  out  1  sticky overflow/drop error
rf_raddr_o  out  5  read address into the inactive bank
rf_rdata_i  in  XLEN  combinational read data from the inactive bank
rf_waddr_o  out  5  write address (inactive bank on fill, active bank on sp update)
rf_wdata_o  out  XLEN  write data
rf_we_o  out  1  write enable
rf_wbank_o  out  1  bank targeted by rf_we_o
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store, 0 = load
mem_addr_o  out  XLEN  byte address
mem_wdata_o  out  XLEN  store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  XLEN  load data

Behaviour:
- Reset rst_ni, asynchronous, active-low; clock clk_i. Reset values: all outputs 0, state IDLE, idx 0, depth 0, pending 0.
- Save order, idx 0..15: ra(1), t0(5), t1(6), t2(7), a0..a7(10..17), t3..t6(28..31). Slot address = base + idx*XLEN/8.
- FSM states: IDLE, SPILL, SP_UPD, FILL_REQ, FILL_WAIT, SWITCH.
- IDLE, ex_valid_i (or pending set), depth<DEPTH_MAX:
  - base_q <= sp_i - NR_SAVED*XLEN/8.
  - bank_sel_o toggles; idx <= 0; next state SPILL.
- IDLE, eret_i, depth>0: base_q <= sp_i; idx <= 0; next state FILL_REQ.
- IDLE, eret_i, depth==0: ignored, no bank switch.
- Priority: ex_valid_i wins over eret_i in the same cycle; that eret_i is dropped and err_o is set.
- SPILL:
  - Outputs: rf_raddr_o = reg[idx], mem_req_o = 1, mem_we_o = 1, mem_addr_o = slot, mem_wdata_o = rf_rdata_i.
  - Request held stable until mem_gnt_i. On gnt, idx++; the gnt on idx==NR_SAVED-1 moves to SP_UPD.
- SP_UPD: one-cycle rf_we_o, rf_wbank_o = bank_sel_o, waddr 2, wdata base_q. depth++; next state IDLE.
- FILL_REQ: load at slot (mem_we_o = 0); on gnt go to FILL_WAIT. At most one load outstanding.
- FILL_WAIT:
  - On mem_rvalid_i: rf_we_o = 1, rf_wbank_o = ~bank_sel_o, waddr reg[idx], wdata mem_rdata_i.
  - Then idx++; next state FILL_REQ, or SWITCH after the last index.
  - rvalid in the same cycle as gnt is not allowed (protocol).
- SWITCH: bank_sel_o toggles; depth--; next state IDLE.
- busy_o = (state != IDLE).
- ex_valid_i while busy: latched into one-deep pending, serviced on return to IDLE. A second one while pending is dropped and sets err_o.
- ex_valid_i at depth==DEPTH_MAX: no switch, err_o set.
- eret_i while busy: dropped, err_o set.
- Address arithmetic is modulo 2^XLEN; no alignment check.
- Reset mid-sequence: aborts immediately, mem_req_o deasserts, bank_sel_o returns to 0, and any late rvalid is ignored.
- Timing with gnt tied 1, ex_valid_i sampled at edge T:
  - stores in cycles T+1..T+16;
  - sp write at T+17;
  - IDLE at T+18.

Decomposition:
- Shared package: saved-register order table (array of 5-bit addresses), NR_SAVED constant, state enum, SP_ADDR = 2.
- No sub-module; a single FSM + idx/depth counters. The slot-address adder may be a local function.

Test Plan:
- Spill with gnt tied 1, sp_i=0x8000_1000, XLEN 64 -> stores to 0x8000_0F80 (data x1) through 0x8000_0FF8 (data x31) in cycles T+1..T+16. sp write 0x8000_0F80 to bank 1 at T+17. bank_sel_o=1, depth=1.
- gnt stall: gnt low 3 cycles on idx 4 -> addr/wdata stable for all 4 cycles, no skipped or duplicated slot.
- Fill after spill, eret_i with sp_i=0x8000_0F80, rvalid 2 cycles after each gnt -> 16 writes into bank 0 with the stored values, then bank_sel_o=0, depth=0.
- eret_i at depth 0 -> no requests, bank_sel_o unchanged, err_o stays 0.
- ex_valid_i during SPILL -> pending; second spill starts the cycle after SP_UPD with base = new sp - 128. A third ex_valid_i while pending -> err_o=1.
- Reset asserted at idx 7 of a spill -> mem_req_o=0 and bank_sel_o=0 immediately. After release, a fresh spill starts at idx 0.
